// File: rtl/seg7_hex_scanner.sv
// Eight-digit hex scanner for a common-anode 7-segment display.
// The shown word is latched once per full scan, so a scan never mixes two words.
module seg7_hex_scanner #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] value_i,
   input  logic        blank_lz_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        scan_done_o
);

   if (REFRESH_DIV < 2) begin : g_bad_refresh_div
      $fatal(1, "seg7_hex_scanner: REFRESH_DIV must be at least 2");
   end

   localparam int unsigned PrescW = $clog2(REFRESH_DIV);
   localparam logic [PrescW-1:0] PrescMax = PrescW'(REFRESH_DIV - 1);

   logic [PrescW-1:0] prescaler_q, prescaler_d;
   logic [2:0]        idx_q, idx_d;
   logic [31:0]       shadow_q, shadow_d;
   logic [7:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              done_q, done_d;

   logic              tick;
   logic              wrap;
   logic              blank;
   logic [3:0]        nibble;
   logic [6:0]        seg_code;

   always_comb begin
      tick        = (prescaler_q == PrescMax);
      wrap        = tick && (idx_q == 3'd7);
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      idx_d       = tick ? idx_q + 3'd1 : idx_q;
      shadow_d    = wrap ? value_i : shadow_q;
      done_d      = wrap;
   end

   // A digit is a leading zero when it and every more significant nibble are zero.
   always_comb begin
      nibble = shadow_q[{idx_q, 2'b00} +: 4];
      blank  = blank_lz_i && (idx_q != 3'd0) && ((shadow_q >> {idx_q, 2'b00}) == 32'h0);
   end

   always_comb begin
      seg_code = 7'h7F;
      unique case (nibble)
         4'h0: seg_code = 7'h40;
         4'h1: seg_code = 7'h79;
         4'h2: seg_code = 7'h24;
         4'h3: seg_code = 7'h30;
         4'h4: seg_code = 7'h19;
         4'h5: seg_code = 7'h12;
         4'h6: seg_code = 7'h02;
         4'h7: seg_code = 7'h78;
         4'h8: seg_code = 7'h00;
         4'h9: seg_code = 7'h10;
         4'hA: seg_code = 7'h08;
         4'hB: seg_code = 7'h03;
         4'hC: seg_code = 7'h46;
         4'hD: seg_code = 7'h21;
         4'hE: seg_code = 7'h06;
         4'hF: seg_code = 7'h0E;
      endcase
   end

   always_comb begin
      an_d  = blank ? 8'hFF : ~(8'h01 << idx_q);
      seg_d = blank ? 7'h7F : seg_code;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prescaler_q <= '0;
         idx_q       <= 3'd0;
         shadow_q    <= 32'h0;
         an_q        <= 8'hFF;
         seg_q       <= 7'h7F;
         done_q      <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         done_q      <= done_d;
      end
   end

   assign an_o        = an_q;
   assign seg_o       = seg_q;
   assign scan_done_o = done_q;

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// Bench for seg7_hex_scanner: per-cycle comparison against an arithmetic model
// of the scan timeline, plus hand-computed checkpoints and a long random run.
module tb_seg7_hex_scanner;

   localparam int unsigned R    = 4;
   localparam int unsigned Scan = 8 * R;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic        blank_lz;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        scan_done;

   int vectors = 0;
   int errors  = 0;

   seg7_hex_scanner #(.REFRESH_DIV(R)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .value_i    (value),
      .blank_lz_i (blank_lz),
      .an_o       (an),
      .seg_o      (seg),
      .scan_done_o(scan_done)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: n = edges since reset release; the digit slot and the latched
   // word follow directly from n.
   int          n = 0;
   int          done_cnt = 0;
   logic [31:0] m_shadow = 32'h0;
   logic [7:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_done;

   always @(posedge clk) begin
      int k;
      if (rst) begin
         n        = 0;
         done_cnt = 0;
         m_shadow = 32'h0;
         exp_an   = 8'hFF;
         exp_seg  = 7'h7F;
         exp_done = 1'b0;
      end else begin
         n++;
         k = ((n - 1) / R) % 8;
         if (k > 0 && blank_lz && (m_shadow >> (4 * k)) == 32'h0) begin
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
         end else begin
            exp_an  = 8'hFF;
            exp_an[k] = 1'b0;
            exp_seg = seg_tab[(m_shadow >> (4 * k)) & 32'hF];
         end
         exp_done = (n % Scan == 0);
         if (exp_done) m_shadow = value;
      end
      #1;
      check("an", {24'h0, an}, {24'h0, exp_an});
      check("seg", {25'h0, seg}, {25'h0, exp_seg});
      check("scan_done", {31'h0, scan_done}, {31'h0, exp_done});
      check("an_at_most_one_low", ($countones(~an) <= 1), 1);
      if (scan_done === 1'b1) done_cnt++;
   end

   int cur = 0;

   task automatic goto(input int e);
      repeat (e - cur) @(posedge clk);
      cur = e;
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cur = 0;
   endtask

   initial begin
      rst      = 1'b1;
      value    = 32'h12345678;
      blank_lz = 1'b0;
      do_reset();

      // Power-up scan: shadow still zero, then 12345678 appears.
      goto(1);  check("e1_an", an, 8'hFE); check("e1_seg", seg, 7'h40);
      goto(4);  check("e4_an", an, 8'hFE); check("e4_seg", seg, 7'h40);
      goto(32); check("e32_done", scan_done, 1'b1);
      goto(33); check("e33_an", an, 8'hFE); check("e33_seg", seg, 7'h00);
      goto(61); check("e61_an", an, 8'h7F); check("e61_seg", seg, 7'h79);

      // Full code sweep.
      value = 32'hFEDCBA98;
      goto(65); check("e65_seg", seg, 7'h00);
      value = 32'h76543210;
      goto(93); check("e93_an", an, 8'h7F); check("e93_seg", seg, 7'h0E);
      goto(97); check("e97_seg", seg, 7'h40);
      goto(125); check("e125_seg", seg, 7'h78);

      // Leading-zero blanking.
      value    = 32'h000000A5;
      blank_lz = 1'b1;
      goto(129); check("lz_d0_an", an, 8'hFE); check("lz_d0_seg", seg, 7'h12);
      goto(133); check("lz_d1_an", an, 8'hFD); check("lz_d1_seg", seg, 7'h08);
      goto(137); check("lz_d2_an", an, 8'hFF); check("lz_d2_seg", seg, 7'h7F);
      value = 32'h0;
      goto(161); check("zero_d0_seg", seg, 7'h40);
      goto(165); check("zero_d1_an", an, 8'hFF);

      // Mid-scan change of value_i is deferred to the next wrap.
      blank_lz = 1'b0;
      value    = 32'h11111111;
      do_reset();
      goto(45); value = 32'h22222222;
      goto(64); check("mid_e64_seg", seg, 7'h79);
      goto(65); check("mid_e65_seg", seg, 7'h24); check("mid_e65_an", an, 8'hFE);

      // Reset while digit 5 is selected.
      goto(85);
      rst = 1'b1;
      goto(86);
      check("rst_an", an, 8'hFF); check("rst_seg", seg, 7'h7F);
      check("rst_done", scan_done, 1'b0);
      rst = 1'b0;
      cur = 0;
      goto(1); check("rst_e1_an", an, 8'hFE); check("rst_e1_seg", seg, 7'h40);
      goto(5); check("rst_e5_an", an, 8'hFD); check("rst_e5_seg", seg, 7'h40);

      // Long random run.
      do_reset();
      for (int e = 1; e <= 10000; e++) begin
         goto(e);
         if ($urandom_range(0, 7) == 0) value = $urandom >> $urandom_range(0, 31);
         blank_lz = 1'($urandom_range(0, 1));
      end
      check("long_done_count", done_cnt, 10000 / Scan);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
